mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words stored; power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  requester asserts to start an access; held high until ack.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-008 wdata  input  32  write data; sampled with req.
REQ-009 ack  output  1  one-cycle pulse marking access completion.
REQ-010 rdata  output  32  read data; valid only in the ack cycle.
REQ-011 err  output  1  access fault flag; valid only in the ack cycle.
REQ-012 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 IDLE with req=1 at a rising edge SHALL latch we/addr/wdata, load the wait counter with WAIT_CYCLES, and go to WAIT (or directly to RESP when WAIT_CYCLES=0).
REQ-015 IDLE with req=0 SHALL remain IDLE; ack, err = 0.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 1.
REQ-017 Latency: ack SHALL be high exactly WAIT_CYCLES+1 cycles after the edge that sampled req.
REQ-018 On the edge entering RESP, a write SHALL commit latched wdata to the latched word; a read SHALL register the word into rdata.
REQ-019 RESP SHALL assert ack for exactly one cycle and always return to IDLE.
REQ-020 Inputs changing during WAIT/RESP SHALL have no effect; only latched values are used.
REQ-021 req still high in the IDLE cycle after ack SHALL be accepted as a new request (back-to-back: one idle cycle between acks).
REQ-022 A read of a word written by the immediately preceding access SHALL return the new data.
REQ-023 rdata SHALL hold its last value outside the ack cycle; for writes, rdata is unchanged.
REQ-024 Addresses beyond DEPTH words SHALL wrap (upper bits ignored) unless REQ-029 applies.

Reset
REQ-025 reset low SHALL immediately force IDLE, counter 0, ack 0, err 0, busy 0, rdata 0.
REQ-026 Reset mid-access SHALL abort it; a pending write not yet committed SHALL NOT modify memory.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 After reset deasserts, the first rising edge with req=1 SHALL be accepted normally.

Configuration
REQ-029 With MEM_RESPONDER_ERR_CHECK_EN defined: addr[1:0]!=0 or any addr bit above log2(DEPTH)+1 set SHALL give err=1 in the ack cycle, suppress the write, and leave rdata unchanged; latency unchanged.
REQ-030 Without MEM_RESPONDER_ERR_CHECK_EN: err SHALL be tied 0, addr[1:0] ignored, and upper bits wrap per REQ-024.

Verification
REQ-031 WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, then read 0x10 -> each ack exactly 3 cycles after sampling; rdata=0xDEADBEEF, err=0.
REQ-032 WAIT_CYCLES=0: req held high for 4 accesses -> ack pulses every 2 cycles; busy high in each RESP cycle.
REQ-033 Reset low during WAIT of a write to 0x20 (previously 0x11111111) -> ack never asserts; subsequent read of 0x20 returns 0x11111111.
REQ-034 ERR_CHECK on: write addr=0x13 -> err=1 in ack cycle, memory unchanged; addr=0x100 (DEPTH=64) -> err=1.
REQ-035 ERR_CHECK off: write 0xCAFEF00D to 0x104 (DEPTH=64), read 0x004 -> rdata=0xCAFEF00D, err=0.
REQ-036 Change addr/wdata/we during WAIT -> access uses values sampled at req edge.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bus between a requester (master) and mem_responder (slave).
//   req    : master holds high until ack
//   we     : 1 = write, 0 = read, sampled with req
//   addr   : byte address, sampled with req
//   wdata  : write data, sampled with req
//   ack    : one-cycle completion pulse
//   rdata  : read data, valid in the ack cycle, held otherwise
//   err    : access fault, valid in the ack cycle
//   busy   : responder is not idle
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Word-addressed memory behind a req/ack handshake with a fixed number of
//   wait states before each response.
//
//   Parameters:
//     DEPTH       : number of 32-bit words (power of two, 4..1024)
//     WAIT_CYCLES : wait states before each response (0..15)
//   Ports:
//     clk_i    : clock, rising edge
//     reset_ni : asynchronous active-low reset
//     bus      : mem_responder_if.slave (req/we/addr/wdata in, ack/rdata/err/busy out)
//   Build option:
//     MEM_RESPONDER_ERR_CHECK_EN : flag misaligned or out-of-range addresses
//       with err in the ack cycle; the faulting access neither writes memory
//       nor updates rdata. Without it, err is 0, addr[1:0] is ignored and the
//       upper address bits wrap.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for req; request fields captured on acceptance
//   WAIT   | counting down wait states, inputs ignored
//   RESP   | ack (and err) high for this one cycle, then back to IDLE
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    mem_responder_if.slave   bus
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            in_err;
    logic            commit;
    logic            acc_we;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            acc_err;

    assign accept = (state_q == S_IDLE) && bus.req;

`ifdef MEM_RESPONDER_ERR_CHECK_EN
    assign in_err = (bus.addr[1:0] != 2'b00) || (|bus.addr[31:AW+2]);
`else
    logic [31-AW:0] unused_addr_bits;
    assign unused_addr_bits = {bus.addr[31:AW+2], bus.addr[1:0]};
    assign in_err = 1'b0;
`endif

    // With zero wait states the commit happens on the accepting edge itself,
    // so the access fields come straight from the bus in that case.
    assign acc_we    = accept ? bus.we              : we_q;
    assign acc_idx   = accept ? bus.addr[AW+1:2]    : idx_q;
    assign acc_wdata = accept ? bus.wdata           : wdata_q;
    assign acc_err   = accept ? in_err              : err_q;

    // Memory has no reset, so commit is gated with reset_ni to keep an
    // access presented while reset is held from landing in the array.
    assign commit = reset_ni &&
                    ((accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1)));

    // state register and captured request
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // next-state and datapath next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            we_d    = bus.we;
            idx_d   = bus.addr[AW+1:2];
            wdata_d = bus.wdata;
            err_d   = in_err;
        end

        if (commit && !acc_we && !acc_err) begin
            rdata_d = mem[acc_idx];
        end
    end

    // outputs
    always_comb begin
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
        bus.busy  = (state_q != S_IDLE);
        bus.rdata = rdata_q;
        if (state_q == S_RESP) begin
            bus.ack = 1'b1;
            bus.err = err_q;
        end
    end

endmodule
